// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer: entry payload, depth and
// register-index width.
package rob_pkg;

  localparam int unsigned ROB_XLEN   = 32;
  localparam int unsigned ROB_TAG_W  = 4;
  localparam int unsigned RF_INDEX_W = 5;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    logic [RF_INDEX_W-1:0] rd_index;
    logic [ROB_XLEN-1:0]   value;
  } rob_entry_t;

  function automatic int unsigned rob_depth(input int unsigned tag_w);
    return 32'd1 << tag_w;
  endfunction

  localparam int unsigned ROB_DEPTH = rob_depth(ROB_TAG_W);

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates rename tags, captures CDB results and
// commits the head in program order. Optional ROB_COMMIT_BYPASS_EN lets a CDB beat to the head commit in the same cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int unsigned XLEN          = ROB_XLEN,
  parameter int unsigned ROB_TAG_WIDTH = ROB_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_valid,
  input  logic [RF_INDEX_W-1:0]    alloc_rd_index,
  output logic                     alloc_ready,
  output logic [ROB_TAG_WIDTH-1:0] alloc_tag,
  input  logic                     cdb_valid,
  input  logic [ROB_TAG_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]          cdb_value,
  input  logic [ROB_TAG_WIDTH-1:0] rs1_tag,
  input  logic [ROB_TAG_WIDTH-1:0] rs2_tag,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [XLEN-1:0]          rs1_value,
  output logic [XLEN-1:0]          rs2_value,
  output logic                     rf_alloc_en,
  output logic [RF_INDEX_W-1:0]    rf_alloc_rd_index,
  output logic [ROB_TAG_WIDTH-1:0] rf_alloc_tag,
  output logic                     rf_write_en,
  output logic [RF_INDEX_W-1:0]    rf_rd_index,
  output logic [XLEN-1:0]          rf_rd,
  output logic [ROB_TAG_WIDTH-1:0] rf_rd_rob_index,
  output logic                     commit_valid,
  output logic                     empty
);

  localparam int unsigned DEPTH = rob_depth(ROB_TAG_WIDTH);
  localparam int unsigned CNT_W = ROB_TAG_WIDTH + 1;

  logic [ROB_TAG_WIDTH-1:0] head_q, head_d;
  logic [ROB_TAG_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  rob_entry_t               entries_q [DEPTH];
  rob_entry_t               entries_d [DEPTH];

  rob_entry_t      head_e;
  logic            fire;
  logic            commit;
  logic [XLEN-1:0] commit_value;

  // Head view, alloc handshake and commit decision.
  always_comb begin
    head_e      = entries_q[head_q];
    alloc_ready = (count_q != CNT_W'(DEPTH));
    fire        = alloc_valid & alloc_ready & ~flush;
`ifdef ROB_COMMIT_BYPASS_EN
    if (cdb_valid && (cdb_tag == head_q) && head_e.busy) begin
      commit       = ~flush;
      commit_value = cdb_value;
    end else begin
      commit       = head_e.busy & head_e.ready & ~flush;
      commit_value = head_e.value;
    end
`else
    commit       = head_e.busy & head_e.ready & ~flush;
    commit_value = head_e.value;
`endif
  end

  assign alloc_tag         = tail_q;
  assign empty             = (count_q == '0);
  assign rf_alloc_en       = fire & (alloc_rd_index != '0);
  assign rf_alloc_rd_index = fire ? alloc_rd_index : '0;
  assign rf_alloc_tag      = tail_q;
  assign commit_valid      = commit;
  assign rf_write_en       = commit & (head_e.rd_index != '0);
  assign rf_rd             = commit_value;
  assign rf_rd_index       = head_e.rd_index;
  assign rf_rd_rob_index   = head_q;

  // Operand lookup reads registered state only.
  assign rs1_ready = entries_q[rs1_tag].busy & entries_q[rs1_tag].ready;
  assign rs2_ready = entries_q[rs2_tag].busy & entries_q[rs2_tag].ready;
  assign rs1_value = entries_q[rs1_tag].value;
  assign rs2_value = entries_q[rs2_tag].value;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_d[i] = '0;
    end else begin
      if (cdb_valid && entries_q[cdb_tag].busy) begin
        entries_d[cdb_tag].ready = 1'b1;
        entries_d[cdb_tag].value = cdb_value;
      end
      if (commit) begin
        entries_d[head_q].busy  = 1'b0;
        entries_d[head_q].ready = 1'b0;
        head_d                  = head_q + 1'b1;
      end
      // Alloc never targets a busy slot, so it cannot collide with CDB or commit.
      if (fire) begin
        entries_d[tail_q].busy     = 1'b1;
        entries_d[tail_q].ready    = 1'b0;
        entries_d[tail_q].rd_index = alloc_rd_index;
        tail_d                     = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(fire) - CNT_W'(commit);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; honours ROB_COMMIT_BYPASS_EN.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, alloc_valid, cdb_valid;
  logic [4:0]  alloc_rd_index;
  logic [3:0]  cdb_tag, rs1_tag, rs2_tag;
  logic [31:0] cdb_value;
  logic        alloc_ready, rs1_ready, rs2_ready, rf_alloc_en, rf_write_en;
  logic        commit_valid, empty;
  logic [3:0]  alloc_tag, rf_alloc_tag, rf_rd_rob_index;
  logic [4:0]  rf_alloc_rd_index, rf_rd_index;
  logic [31:0] rs1_value, rs2_value, rf_rd;

  int pass_cnt = 0;
  int total    = 0;

  reorder_buffer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd_index(alloc_rd_index),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rf_alloc_en(rf_alloc_en), .rf_alloc_rd_index(rf_alloc_rd_index),
    .rf_alloc_tag(rf_alloc_tag), .rf_write_en(rf_write_en),
    .rf_rd_index(rf_rd_index), .rf_rd(rf_rd), .rf_rd_rob_index(rf_rd_rob_index),
    .commit_valid(commit_valid), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; cdb_valid = 1'b0;
    alloc_rd_index = '0; cdb_tag = '0; cdb_value = '0; rs1_tag = '0; rs2_tag = '0;
    #2;
    total++; if (alloc_ready !== 1'b1) $display("FAIL rst_alloc_ready got %b exp 1", alloc_ready); else pass_cnt++;
    total++; if (alloc_tag !== 4'd0) $display("FAIL rst_alloc_tag got %0d exp 0", alloc_tag); else pass_cnt++;
    total++; if (empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty); else pass_cnt++;
    total++; if ({rf_alloc_en, rf_write_en, commit_valid} !== 3'b000)
      $display("FAIL rst_enables got %b exp 000", {rf_alloc_en, rf_write_en, commit_valid}); else pass_cnt++;
    total++; if ({rf_rd, rf_rd_index, rf_rd_rob_index, rf_alloc_tag, rf_alloc_rd_index} !== '0)
      $display("FAIL rst_rf_buses got %h exp 0", {rf_rd, rf_rd_index, rf_rd_rob_index}); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  // T1 + T2: single alloc, completion and commit.
  task automatic test_alloc_commit();
    alloc_valid = 1'b1; alloc_rd_index = 5'd3;
    #1;
    total++; if (alloc_tag !== 4'd0) $display("FAIL t1_alloc_tag got %0d exp 0", alloc_tag); else pass_cnt++;
    total++; if (rf_alloc_en !== 1'b1) $display("FAIL t1_rf_alloc_en got %b exp 1", rf_alloc_en); else pass_cnt++;
    total++; if (rf_alloc_rd_index !== 5'd3) $display("FAIL t1_rf_alloc_rd got %0d exp 3", rf_alloc_rd_index); else pass_cnt++;
    total++; if (rf_alloc_tag !== 4'd0) $display("FAIL t1_rf_alloc_tag got %0d exp 0", rf_alloc_tag); else pass_cnt++;
    tick();
    alloc_valid = 1'b0; alloc_rd_index = '0;
    #1;
    total++; if (empty !== 1'b0) $display("FAIL t1_empty got %b exp 0", empty); else pass_cnt++;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h0123_4567;
    #1;
`ifdef ROB_COMMIT_BYPASS_EN
    total++; if ({commit_valid, rf_write_en} !== 2'b11) $display("FAIL t2_byp_commit got %b exp 11", {commit_valid, rf_write_en}); else pass_cnt++;
    total++; if (rf_rd !== 32'h0123_4567) $display("FAIL t2_byp_rd got %h exp 01234567", rf_rd); else pass_cnt++;
    tick();
    cdb_valid = 1'b0;
    #1;
`else
    total++; if (commit_valid !== 1'b0) $display("FAIL t2_early_commit got %b exp 0", commit_valid); else pass_cnt++;
    tick();
    cdb_valid = 1'b0;
    #1;
    total++; if (rf_write_en !== 1'b1) $display("FAIL t2_write_en got %b exp 1", rf_write_en); else pass_cnt++;
    total++; if (rf_rd_index !== 5'd3) $display("FAIL t2_rd_index got %0d exp 3", rf_rd_index); else pass_cnt++;
    total++; if (rf_rd !== 32'h0123_4567) $display("FAIL t2_rd got %h exp 01234567", rf_rd); else pass_cnt++;
    total++; if (rf_rd_rob_index !== 4'd0) $display("FAIL t2_rob_index got %0d exp 0", rf_rd_rob_index); else pass_cnt++;
    tick();
`endif
    total++; if (empty !== 1'b1) $display("FAIL t2_empty_after got %b exp 1", empty); else pass_cnt++;
  endtask

  // T3: younger completes first; commits stay in order.
  task automatic test_out_of_order();
    do_reset();
    alloc_valid = 1'b1; alloc_rd_index = 5'd5;
    tick();
    alloc_rd_index = 5'd6;
    #1;
    total++; if (alloc_tag !== 4'd1) $display("FAIL t3_second_tag got %0d exp 1", alloc_tag); else pass_cnt++;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'hAAAA_0001;
    tick();
    cdb_valid = 1'b0;
    rs1_tag = 4'd1; rs2_tag = 4'd0;
    #1;
    total++; if (commit_valid !== 1'b0) $display("FAIL t3_no_commit got %b exp 0", commit_valid); else pass_cnt++;
    total++; if ({rs1_ready, rs2_ready} !== 2'b10) $display("FAIL t3_rs_ready got %b exp 10", {rs1_ready, rs2_ready}); else pass_cnt++;
    total++; if (rs1_value !== 32'hAAAA_0001) $display("FAIL t3_rs1_value got %h exp aaaa0001", rs1_value); else pass_cnt++;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'hBBBB_0000;
`ifdef ROB_COMMIT_BYPASS_EN
    #1;
`else
    tick();
    cdb_valid = 1'b0;
    #1;
`endif
    total++; if ({commit_valid, rf_rd_rob_index, rf_rd_index} !== {1'b1, 4'd0, 5'd5})
      $display("FAIL t3_commit0 got v=%b tag=%0d rd=%0d exp v=1 tag=0 rd=5", commit_valid, rf_rd_rob_index, rf_rd_index); else pass_cnt++;
    total++; if (rf_rd !== 32'hBBBB_0000) $display("FAIL t3_value0 got %h exp bbbb0000", rf_rd); else pass_cnt++;
    tick();
    cdb_valid = 1'b0;
    #1;
    total++; if ({commit_valid, rf_rd_rob_index, rf_rd_index} !== {1'b1, 4'd1, 5'd6})
      $display("FAIL t3_commit1 got v=%b tag=%0d rd=%0d exp v=1 tag=1 rd=6", commit_valid, rf_rd_rob_index, rf_rd_index); else pass_cnt++;
    total++; if (rf_rd !== 32'hAAAA_0001) $display("FAIL t3_value1 got %h exp aaaa0001", rf_rd); else pass_cnt++;
    tick();
    total++; if (empty !== 1'b1) $display("FAIL t3_empty got %b exp 1", empty); else pass_cnt++;
  endtask

  // T4: fill all 16 slots, reject overflow, then wrap the tail.
  task automatic test_fill_wrap();
    int bad_tags;
    do_reset();
    bad_tags = 0;
    alloc_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      alloc_rd_index = 5'(i + 1);
      #1;
      if (alloc_tag !== 4'(i)) bad_tags++;
      tick();
    end
    total++; if (bad_tags != 0) $display("FAIL t4_fill_tags got %0d wrong exp 0", bad_tags); else pass_cnt++;
    alloc_rd_index = 5'd7;
    #1;
    total++; if (alloc_ready !== 1'b0) $display("FAIL t4_full_ready got %b exp 0", alloc_ready); else pass_cnt++;
    total++; if (rf_alloc_en !== 1'b0) $display("FAIL t4_overflow_en got %b exp 0", rf_alloc_en); else pass_cnt++;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_value = 32'h0000_0011;
    tick();
    cdb_tag = 4'd0; cdb_value = 32'h0000_0010;
`ifdef ROB_COMMIT_BYPASS_EN
    alloc_valid = 1'b1; alloc_rd_index = 5'd9;
    #1;
`else
    tick();
    cdb_valid = 1'b0;
    alloc_valid = 1'b1; alloc_rd_index = 5'd9;
    #1;
`endif
    total++; if ({commit_valid, rf_rd_index} !== {1'b1, 5'd1})
      $display("FAIL t4_commit_head got v=%b rd=%0d exp v=1 rd=1", commit_valid, rf_rd_index); else pass_cnt++;
    total++; if ({alloc_ready, rf_alloc_en} !== 2'b00)
      $display("FAIL t4_no_alloc_on_commit got %b exp 00", {alloc_ready, rf_alloc_en}); else pass_cnt++;
    tick();
    cdb_valid = 1'b0;
    #1;
    total++; if ({alloc_ready, alloc_tag, rf_alloc_en} !== {1'b1, 4'd0, 1'b1})
      $display("FAIL t4_wrap_alloc got rdy=%b tag=%0d en=%b exp 1 0 1", alloc_ready, alloc_tag, rf_alloc_en); else pass_cnt++;
    total++; if ({commit_valid, rf_rd_rob_index, rf_rd} !== {1'b1, 4'd1, 32'h0000_0011})
      $display("FAIL t4_same_cycle_commit got v=%b tag=%0d val=%h exp 1 1 11", commit_valid, rf_rd_rob_index, rf_rd); else pass_cnt++;
    tick();
    alloc_valid = 1'b0;
    #1;
    total++; if ({alloc_ready, alloc_tag, commit_valid, empty} !== {1'b1, 4'd1, 1'b0, 1'b0})
      $display("FAIL t4_after_swap got rdy=%b tag=%0d cv=%b empty=%b exp 1 1 0 0", alloc_ready, alloc_tag, commit_valid, empty); else pass_cnt++;
    alloc_valid = 1'b1; alloc_rd_index = 5'd12;
    tick();
    alloc_valid = 1'b0;
    #1;
    total++; if (alloc_ready !== 1'b0) $display("FAIL t4_refull got %b exp 0", alloc_ready); else pass_cnt++;
  endtask

  // T5: instruction without a destination register.
  task automatic test_x0_dest();
    do_reset();
    alloc_valid = 1'b1; alloc_rd_index = 5'd0;
    #1;
    total++; if ({alloc_ready, rf_alloc_en} !== 2'b10) $display("FAIL t5_alloc_en got %b exp 10", {alloc_ready, rf_alloc_en}); else pass_cnt++;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'h5555_5555;
`ifdef ROB_COMMIT_BYPASS_EN
    #1;
`else
    tick();
    cdb_valid = 1'b0;
    #1;
`endif
    total++; if ({commit_valid, rf_write_en} !== 2'b10) $display("FAIL t5_commit got %b exp 10", {commit_valid, rf_write_en}); else pass_cnt++;
    tick();
    cdb_valid = 1'b0;
    #1;
    total++; if ({empty, rf_rd_rob_index, alloc_tag} !== {1'b1, 4'd1, 4'd1})
      $display("FAIL t5_head_adv got empty=%b head=%0d tail=%0d exp 1 1 1", empty, rf_rd_rob_index, alloc_tag); else pass_cnt++;
  endtask

  // T6: flush wins over CDB/alloc/commit; async reset drops a pending commit.
  task automatic test_flush_reset();
    do_reset();
    alloc_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      alloc_rd_index = 5'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'hDEAD_0000;
    tick();
    flush = 1'b1; cdb_tag = 4'd1; cdb_value = 32'hDEAD_0001;
    alloc_valid = 1'b1; alloc_rd_index = 5'd9;
    #1;
    total++; if ({commit_valid, rf_write_en, rf_alloc_en} !== 3'b000)
      $display("FAIL t6_flush_gates got %b exp 000", {commit_valid, rf_write_en, rf_alloc_en}); else pass_cnt++;
    tick();
    flush = 1'b0; cdb_valid = 1'b0; alloc_valid = 1'b0;
    rs1_tag = 4'd1;
    #1;
    total++; if ({empty, alloc_ready, alloc_tag, rs1_ready} !== {1'b1, 1'b1, 4'd0, 1'b0})
      $display("FAIL t6_after_flush got empty=%b rdy=%b tag=%0d rs1=%b exp 1 1 0 0", empty, alloc_ready, alloc_tag, rs1_ready); else pass_cnt++;
    alloc_valid = 1'b1; alloc_rd_index = 5'd4;
    tick();
    alloc_valid = 1'b0;
    cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_value = 32'hCAFE_F00D;
    tick();
    cdb_valid = 1'b0;
`ifndef ROB_COMMIT_BYPASS_EN
    #1;
    total++; if (rf_write_en !== 1'b1) $display("FAIL t6_pre_reset_commit got %b exp 1", rf_write_en); else pass_cnt++;
`endif
    reset = 1'b1;
    #1;
    total++; if ({commit_valid, rf_write_en, empty, alloc_tag} !== {1'b0, 1'b0, 1'b1, 4'd0})
      $display("FAIL t6_async_reset got cv=%b we=%b empty=%b tag=%0d exp 0 0 1 0", commit_valid, rf_write_en, empty, alloc_tag); else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alloc_commit();
    test_out_of_order();
    test_fill_wrap();
    test_x0_dest();
    test_flush_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
